// File: rtl/mispredict_revert_controller.sv
// Branch-mispredict recovery: checkpoint restore, else youngest-first ROB walk reverting rename mappings, then ROB tail rollback.
// Latency: restore at T+1; reverts one entry per cycle after that (or from T+1 without checkpoint); rollback the cycle after the last step.
// No backpressure: one step per cycle; mispredicts arriving while busy are dropped and flagged on DUT_error.
module mispredict_revert_controller #(
    parameter  int ROB_DEPTH          = 16,
    parameter  int NUM_ARCH_REGS      = 32,
    parameter  int NUM_PHYS_REGS      = 64,
    parameter  int CHECKPOINT_COLUMNS = 4,
    localparam int LOG_ROB_DEPTH      = $clog2(ROB_DEPTH),
    localparam int ARCH_W             = $clog2(NUM_ARCH_REGS),
    localparam int PHYS_W             = $clog2(NUM_PHYS_REGS),
    localparam int COL_W              = $clog2(CHECKPOINT_COLUMNS)
) (
    input  logic                     CLK,
    input  logic                     RST,
    output logic                     DUT_error,
    input  logic                     mispredict_valid,
    input  logic [LOG_ROB_DEPTH-1:0] mispredict_ROB_index,
    input  logic                     mispredict_checkpoint_valid,
    input  logic [COL_W-1:0]         mispredict_checkpoint_column,
    input  logic [LOG_ROB_DEPTH-1:0] rob_tail_index,
    output logic [LOG_ROB_DEPTH-1:0] rob_read_index,
    input  logic                     rob_read_writes_reg,
    input  logic [ARCH_W-1:0]        rob_read_arch_reg,
    input  logic [PHYS_W-1:0]        rob_read_safe_phys_reg,
    input  logic [PHYS_W-1:0]        rob_read_spec_phys_reg,
    output logic                     restore_checkpoint_valid,
    output logic                     restore_checkpoint_speculate_failed,
    output logic [LOG_ROB_DEPTH-1:0] restore_checkpoint_ROB_index,
    output logic [COL_W-1:0]         restore_checkpoint_safe_column,
    input  logic                     restore_checkpoint_success,
    output logic                     revert_valid,
    output logic [ARCH_W-1:0]        revert_dest_arch_reg_tag,
    output logic [PHYS_W-1:0]        revert_safe_dest_phys_reg_tag,
    output logic [PHYS_W-1:0]        revert_speculated_dest_phys_reg_tag,
    output logic                     rob_rollback_valid,
    output logic [LOG_ROB_DEPTH-1:0] rob_rollback_tail_index,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESTORE = 2'd1,
        WALK    = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [LOG_ROB_DEPTH-1:0] ROB_ONE  = LOG_ROB_DEPTH'(1);
    localparam logic [LOG_ROB_DEPTH-1:0] ROB_ZERO = '0;

    state_e                     state_q;
    logic [LOG_ROB_DEPTH-1:0]   walk_ptr_q;
    logic [LOG_ROB_DEPTH-1:0]   walk_count_q;
    logic [LOG_ROB_DEPTH-1:0]   idx_q;
    logic [COL_W-1:0]           col_q;
    logic                       err_q;

    // Entries strictly younger than the mispredicting one; modulo arithmetic handles wrap and the full-ROB case.
    logic [LOG_ROB_DEPTH-1:0]   walk_count_d;
    logic [LOG_ROB_DEPTH-1:0]   walk_ptr_d;
    assign walk_count_d = rob_tail_index - mispredict_ROB_index - ROB_ONE;
    assign walk_ptr_d   = rob_tail_index - ROB_ONE;

    // Recovery sequencer: capture on mispredict, restore, walk, rollback; flag mispredicts seen while busy.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            walk_ptr_q   <= '0;
            walk_count_q <= '0;
            idx_q        <= '0;
            col_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            err_q <= mispredict_valid && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (mispredict_valid) begin
                        idx_q        <= mispredict_ROB_index;
                        col_q        <= mispredict_checkpoint_column;
                        walk_count_q <= walk_count_d;
                        walk_ptr_q   <= walk_ptr_d;
                        if (mispredict_checkpoint_valid) begin
                            state_q <= RESTORE;
                        end else if (walk_count_d != ROB_ZERO) begin
                            state_q <= WALK;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                RESTORE: begin
                    if (restore_checkpoint_success || (walk_count_q == ROB_ZERO)) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= WALK;
                    end
                end
                WALK: begin
                    walk_ptr_q   <= walk_ptr_q - ROB_ONE;
                    walk_count_q <= walk_count_q - ROB_ONE;
                    if (walk_count_q == ROB_ONE) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    logic in_restore;
    logic in_walk;
    logic in_done;
    assign in_restore = (state_q == RESTORE);
    assign in_walk    = (state_q == WALK);
    assign in_done    = (state_q == DONE);

    // Outputs decode from registered state; payloads are zeroed outside their state so idle outputs are quiet.
    assign busy                                = (state_q != IDLE);
    assign DUT_error                           = err_q;
    assign rob_read_index                      = walk_ptr_q;
    assign restore_checkpoint_valid            = in_restore;
    assign restore_checkpoint_speculate_failed = in_restore;
    assign restore_checkpoint_ROB_index        = in_restore ? idx_q : '0;
    assign restore_checkpoint_safe_column      = in_restore ? col_q : '0;
    assign revert_valid                        = in_walk && rob_read_writes_reg;
    assign revert_dest_arch_reg_tag            = in_walk ? rob_read_arch_reg : '0;
    assign revert_safe_dest_phys_reg_tag       = in_walk ? rob_read_safe_phys_reg : '0;
    assign revert_speculated_dest_phys_reg_tag = in_walk ? rob_read_spec_phys_reg : '0;
    assign rob_rollback_valid                  = in_done;
    assign rob_rollback_tail_index             = in_done ? (idx_q + ROB_ONE) : '0;

endmodule

// File: tb/tb_mispredict_revert_controller.sv
// Scoreboard bench for mispredict_revert_controller: directed mispredict scenarios push expected per-cycle outputs.
// A negedge monitor pops one expectation for every busy (or error) cycle and compares cycle number and payload.
// Inputs are driven 1 time unit after the rising edge.
module tb_mispredict_revert_controller;

    logic       CLK = 1'b0;
    logic       RST;
    logic       DUT_error;
    logic       mispredict_valid;
    logic [3:0] mispredict_ROB_index;
    logic       mispredict_checkpoint_valid;
    logic [1:0] mispredict_checkpoint_column;
    logic [3:0] rob_tail_index;
    logic [3:0] rob_read_index;
    logic       rob_read_writes_reg;
    logic [4:0] rob_read_arch_reg;
    logic [5:0] rob_read_safe_phys_reg;
    logic [5:0] rob_read_spec_phys_reg;
    logic       restore_checkpoint_valid;
    logic       restore_checkpoint_speculate_failed;
    logic [3:0] restore_checkpoint_ROB_index;
    logic [1:0] restore_checkpoint_safe_column;
    logic       restore_checkpoint_success;
    logic       revert_valid;
    logic [4:0] revert_dest_arch_reg_tag;
    logic [5:0] revert_safe_dest_phys_reg_tag;
    logic [5:0] revert_speculated_dest_phys_reg_tag;
    logic       rob_rollback_valid;
    logic [3:0] rob_rollback_tail_index;
    logic       busy;

    always #5 CLK = ~CLK;

    mispredict_revert_controller dut (
        .CLK                                 (CLK),
        .RST                                 (RST),
        .DUT_error                           (DUT_error),
        .mispredict_valid                    (mispredict_valid),
        .mispredict_ROB_index                (mispredict_ROB_index),
        .mispredict_checkpoint_valid         (mispredict_checkpoint_valid),
        .mispredict_checkpoint_column        (mispredict_checkpoint_column),
        .rob_tail_index                      (rob_tail_index),
        .rob_read_index                      (rob_read_index),
        .rob_read_writes_reg                 (rob_read_writes_reg),
        .rob_read_arch_reg                   (rob_read_arch_reg),
        .rob_read_safe_phys_reg              (rob_read_safe_phys_reg),
        .rob_read_spec_phys_reg              (rob_read_spec_phys_reg),
        .restore_checkpoint_valid            (restore_checkpoint_valid),
        .restore_checkpoint_speculate_failed (restore_checkpoint_speculate_failed),
        .restore_checkpoint_ROB_index        (restore_checkpoint_ROB_index),
        .restore_checkpoint_safe_column      (restore_checkpoint_safe_column),
        .restore_checkpoint_success          (restore_checkpoint_success),
        .revert_valid                        (revert_valid),
        .revert_dest_arch_reg_tag            (revert_dest_arch_reg_tag),
        .revert_safe_dest_phys_reg_tag       (revert_safe_dest_phys_reg_tag),
        .revert_speculated_dest_phys_reg_tag (revert_speculated_dest_phys_reg_tag),
        .rob_rollback_valid                  (rob_rollback_valid),
        .rob_rollback_tail_index             (rob_rollback_tail_index),
        .busy                                (busy)
    );

    // Small ROB model answering the combinational read port.
    logic       rob_wr   [16];
    logic [4:0] rob_arch [16];
    logic [5:0] rob_safe [16];
    logic [5:0] rob_spec [16];
    assign rob_read_writes_reg    = rob_wr[rob_read_index];
    assign rob_read_arch_reg      = rob_arch[rob_read_index];
    assign rob_read_safe_phys_reg = rob_safe[rob_read_index];
    assign rob_read_spec_phys_reg = rob_spec[rob_read_index];

    typedef struct packed {
        logic       rv;
        logic       sf;
        logic [3:0] ridx;
        logic [1:0] col;
        logic       vv;
        logic [4:0] arch;
        logic [5:0] safe;
        logic [5:0] spec;
        logic       bv;
        logic [3:0] btail;
        logic [3:0] rd;
        logic       err;
    } obs_t;

    typedef struct {
        int   cyc;
        logic chk_rd;
        obs_t o;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic mon_en = 1'b0;
    obs_t mon_a;
    exp_t mon_e;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void push(int c, logic chk, obs_t o);
        exp_t e;
        e.cyc = c;
        e.chk_rd = chk;
        e.o = o;
        q.push_back(e);
    endfunction

    function automatic void push_restore(int c, logic [3:0] idx, logic [1:0] col);
        obs_t o = '0;
        o.rv = 1'b1;
        o.sf = 1'b1;
        o.ridx = idx;
        o.col = col;
        push(c, 1'b0, o);
    endfunction

    function automatic void push_walk(int c, logic [3:0] ptr);
        obs_t o = '0;
        o.rd = ptr;
        o.vv = rob_wr[ptr];
        if (rob_wr[ptr]) begin
            o.arch = rob_arch[ptr];
            o.safe = rob_safe[ptr];
            o.spec = rob_spec[ptr];
        end
        push(c, 1'b1, o);
    endfunction

    function automatic void push_done(int c, logic [3:0] tail);
        obs_t o = '0;
        o.bv = 1'b1;
        o.btail = tail;
        push(c, 1'b0, o);
    endfunction

    function automatic void set_err(int c);
        foreach (q[i]) if (q[i].cyc == c) q[i].o.err = 1'b1;
    endfunction

    function automatic void flush_from(int c);
        exp_t keep[$];
        foreach (q[i]) if (q[i].cyc < c) keep.push_back(q[i]);
        q = keep;
    endfunction

    // Monitor: every busy/error cycle must match the next scoreboard entry, including its cycle number.
    always @(negedge CLK) begin
        if (mon_en) begin
            mon_a.rv    = restore_checkpoint_valid;
            mon_a.sf    = restore_checkpoint_speculate_failed;
            mon_a.ridx  = restore_checkpoint_ROB_index;
            mon_a.col   = restore_checkpoint_safe_column;
            mon_a.vv    = revert_valid;
            mon_a.arch  = revert_valid ? revert_dest_arch_reg_tag : 5'd0;
            mon_a.safe  = revert_valid ? revert_safe_dest_phys_reg_tag : 6'd0;
            mon_a.spec  = revert_valid ? revert_speculated_dest_phys_reg_tag : 6'd0;
            mon_a.bv    = rob_rollback_valid;
            mon_a.btail = rob_rollback_tail_index;
            mon_a.rd    = rob_read_index;
            mon_a.err   = DUT_error;
            if (busy || DUT_error) begin
                n_chk++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_output cyc=%0d got=%h (nothing expected)", cyc, mon_a);
                end else begin
                    mon_e = q.pop_front();
                    if (!mon_e.chk_rd) mon_a.rd = 4'd0;
                    if (mon_e.cyc == cyc && mon_a === mon_e.o) n_pass++;
                    else $display("FAIL seq_step cyc=%0d exp_cyc=%0d got=%h want=%h", cyc, mon_e.cyc, mon_a, mon_e.o);
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                n_chk++;
                $display("FAIL missing_output cyc=%0d exp_cyc=%0d got=idle want=%h", cyc, q[0].cyc, q[0].o);
                void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    endtask

    task automatic fire(logic [3:0] idx, logic [3:0] tail, logic ckv, logic [1:0] col, logic succ);
        mispredict_ROB_index         = idx;
        rob_tail_index               = tail;
        mispredict_checkpoint_valid  = ckv;
        mispredict_checkpoint_column = col;
        restore_checkpoint_success   = succ;
        mispredict_valid             = 1'b1;
        step();
        mispredict_valid             = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && busy; k++) step();
        if (busy) begin
            n_chk++;
            $display("FAIL idle_timeout cyc=%0d got=busy want=idle", cyc);
        end
        step();
        step();
    endtask

    int t0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            rob_wr[i]   = 1'b1;
            rob_arch[i] = 5'(i + 10);
            rob_safe[i] = 6'(i);
            rob_spec[i] = 6'(i + 20);
        end
        rob_arch[8] = 5'd3; rob_safe[8] = 6'd40; rob_spec[8] = 6'd50;
        rob_arch[7] = 5'd4; rob_safe[7] = 6'd41; rob_spec[7] = 6'd51;
        rob_arch[6] = 5'd5; rob_safe[6] = 6'd42; rob_spec[6] = 6'd52;

        RST = 1'b1;
        mispredict_valid = 1'b0;
        mispredict_ROB_index = '0;
        mispredict_checkpoint_valid = 1'b0;
        mispredict_checkpoint_column = '0;
        rob_tail_index = '0;
        restore_checkpoint_success = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_restore_valid", 32'(restore_checkpoint_valid), 0);
        chk("rst_revert_valid", 32'(revert_valid), 0);
        chk("rst_rollback_valid", 32'(rob_rollback_valid), 0);
        chk("rst_error", 32'(DUT_error), 0);
        chk("rst_read_index", 32'(rob_read_index), 0);
        RST = 1'b0;
        mon_en = 1'b1;
        step();

        // 1: checkpoint restore succeeds
        t0 = cyc;
        push_restore(t0 + 1, 4'd5, 2'd2);
        push_done(t0 + 2, 4'd6);
        fire(4'd5, 4'd9, 1'b1, 2'd2, 1'b1);
        wait_idle();

        // 2: restore fails, walk 8,7,6
        t0 = cyc;
        push_restore(t0 + 1, 4'd5, 2'd2);
        push_walk(t0 + 2, 4'd8);
        push_walk(t0 + 3, 4'd7);
        push_walk(t0 + 4, 4'd6);
        push_done(t0 + 5, 4'd6);
        fire(4'd5, 4'd9, 1'b1, 2'd2, 1'b0);
        wait_idle();

        // 3: no checkpoint, entry 7 writes no register
        rob_wr[7] = 1'b0;
        t0 = cyc;
        push_walk(t0 + 1, 4'd8);
        push_walk(t0 + 2, 4'd7);
        push_walk(t0 + 3, 4'd6);
        push_done(t0 + 4, 4'd6);
        fire(4'd5, 4'd9, 1'b0, 2'd0, 1'b1);
        wait_idle();

        // 4: wrap around the ROB end
        t0 = cyc;
        push_walk(t0 + 1, 4'd1);
        push_walk(t0 + 2, 4'd0);
        push_walk(t0 + 3, 4'd15);
        push_done(t0 + 4, 4'd15);
        fire(4'd14, 4'd2, 1'b0, 2'd0, 1'b0);
        wait_idle();

        // 5a: nothing younger than the branch
        t0 = cyc;
        push_done(t0 + 1, 4'd6);
        fire(4'd5, 4'd6, 1'b0, 2'd0, 1'b0);
        wait_idle();

        // 5b: full ROB, 15 walk cycles
        t0 = cyc;
        for (int k = 0; k < 15; k++) push_walk(t0 + 1 + k, 4'(2 - k));
        push_done(t0 + 16, 4'd4);
        fire(4'd3, 4'd3, 1'b0, 2'd0, 1'b0);
        wait_idle();

        // 6a: second mispredict during WALK is dropped and flagged
        t0 = cyc;
        push_walk(t0 + 1, 4'd8);
        push_walk(t0 + 2, 4'd7);
        push_walk(t0 + 3, 4'd6);
        push_done(t0 + 4, 4'd6);
        set_err(t0 + 2);
        mispredict_ROB_index = 4'd5;
        rob_tail_index = 4'd9;
        mispredict_checkpoint_valid = 1'b0;
        mispredict_valid = 1'b1;
        step();
        mispredict_ROB_index = 4'd0;
        mispredict_checkpoint_valid = 1'b1;
        step();
        mispredict_valid = 1'b0;
        wait_idle();

        // 6b: reset in the middle of a walk aborts it
        t0 = cyc;
        for (int k = 0; k < 15; k++) push_walk(t0 + 1 + k, 4'(2 - k));
        push_done(t0 + 16, 4'd4);
        fire(4'd3, 4'd3, 1'b0, 2'd0, 1'b0);
        step();
        step();
        RST = 1'b1;
        flush_from(t0 + 4);
        step();
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_rollback", 32'(rob_rollback_valid), 0);
        chk("midrst_revert", 32'(revert_valid), 0);
        RST = 1'b0;
        for (int k = 0; k < 20; k++) step();
        chk("scoreboard_drained", 32'(q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
